// File: rtl/controlador_pontos_placar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : controlador_pontos_placar_pkg
// Brief    : Shared types and constants for the scoreboard point controller.
// Revision : 1.0 - initial release
// ============================================================================
package controlador_pontos_placar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } estado_t;

    localparam logic TIME_A = 1'b0;
    localparam logic TIME_B = 1'b1;

    localparam int SCORE_W        = 7;
    localparam int MAX_PONTOS_DEF = 99;

endpackage : controlador_pontos_placar_pkg
`default_nettype wire

// File: rtl/controlador_pontos_placar_if.sv
`default_nettype none
// ============================================================================
// Module   : controlador_pontos_placar_if
// Brief    : Point-request inputs and team-register bus of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface controlador_pontos_placar_if;
    import controlador_pontos_placar_pkg::*;

    logic               req_a;
    logic [1:0]         pts_a;
    logic               req_b;
    logic [1:0]         pts_b;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic [SCORE_W-1:0] d_a;
    logic               valida_a;
    logic [SCORE_W-1:0] d_b;
    logic               valida_b;
    logic               busy;
    logic               perdido;

    modport master (
        output req_a, pts_a, req_b, pts_b, score_a, score_b,
        input  d_a, valida_a, d_b, valida_b, busy, perdido
    );

    modport slave (
        input  req_a, pts_a, req_b, pts_b, score_a, score_b,
        output d_a, valida_a, d_b, valida_b, busy, perdido
    );

endinterface : controlador_pontos_placar_if
`default_nettype wire

// File: rtl/controlador_pontos_placar_somador_saturado.sv
`default_nettype none
// ============================================================================
// Module   : somador_saturado
// Brief    : Score + points, clamped to MAX_PONTOS (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module somador_saturado
    import controlador_pontos_placar_pkg::*;
#(
    parameter int MAX_PONTOS = MAX_PONTOS_DEF
) (
    input  wire logic [SCORE_W-1:0] score_i,
    input  wire logic [1:0]         pts_i,
    output logic      [SCORE_W-1:0] soma_o
);

    // One extra bit so 127 + 3 cannot wrap below the ceiling.
    logic [SCORE_W:0] w_soma;

    always_comb begin
        w_soma = {1'b0, score_i} + {{(SCORE_W-1){1'b0}}, pts_i};
        if (w_soma >= (SCORE_W+1)'(MAX_PONTOS)) begin
            soma_o = SCORE_W'(MAX_PONTOS);
        end else begin
            soma_o = w_soma[SCORE_W-1:0];
        end
    end

endmodule : somador_saturado
`default_nettype wire

// File: rtl/controlador_pontos_placar.sv
`default_nettype none
// ============================================================================
// Module   : controlador_pontos_placar
// Brief    : Round-robin point sequencer driving the two team-score registers.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_pontos_placar
    import controlador_pontos_placar_pkg::*;
#(
    parameter int MAX_PONTOS  = MAX_PONTOS_DEF,
    parameter int HOLD_CYCLES = 4
) (
    input  wire logic                  clock_i,
    input  wire logic                  clr_i,
    controlador_pontos_placar_if.slave bus
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    estado_t            state_q, state_d;
    logic               pend_a_q, pend_b_q;
    logic [1:0]         pts_a_q, pts_b_q, pts_gnt_q;
    logic               team_q;
    logic [SCORE_W-1:0] d_a_q, d_b_q;
    logic               perdido_q;
    logic [CNT_W-1:0]   hold_cnt_q;

    logic               w_req_a, w_req_b;
    logic               w_gnt_en, w_gnt_team, w_gnt_a, w_gnt_b;
    logic               w_drop_a, w_drop_b;
    logic [SCORE_W-1:0] w_score_sel, w_soma;
    logic               w_valida_a, w_valida_b, w_busy;

    assign w_req_a = bus.req_a && (bus.pts_a != 2'd0);
    assign w_req_b = bus.req_b && (bus.pts_b != 2'd0);

    // On a tie the team not served last wins; team_q doubles as last-served.
    assign w_gnt_en   = (state_q == IDLE) && (pend_a_q || pend_b_q);
    assign w_gnt_team = (pend_a_q && pend_b_q) ? ~team_q :
                        (pend_a_q ? TIME_A : TIME_B);
    assign w_gnt_a    = w_gnt_en && (w_gnt_team == TIME_A);
    assign w_gnt_b    = w_gnt_en && (w_gnt_team == TIME_B);

    assign w_drop_a = w_req_a && pend_a_q && !w_gnt_a;
    assign w_drop_b = w_req_b && pend_b_q && !w_gnt_b;

    assign w_score_sel = (team_q == TIME_A) ? bus.score_a : bus.score_b;

    somador_saturado #(
        .MAX_PONTOS (MAX_PONTOS)
    ) u_somador (
        .score_i (w_score_sel),
        .pts_i   (pts_gnt_q),
        .soma_o  (w_soma)
    );

    always_ff @(posedge clock_i) begin
        if (!clr_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_valida_a = 1'b0;
        w_valida_b = 1'b0;
        w_busy     = (state_q != IDLE);
        case (state_q)
            IDLE:  if (w_gnt_en) state_d = CALC;
            CALC:  state_d = PULSE;
            PULSE: begin
                state_d    = HOLD;
                w_valida_a = (team_q == TIME_A);
                w_valida_b = (team_q == TIME_B);
            end
            HOLD:  if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!clr_i) begin
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            pts_a_q    <= 2'd0;
            pts_b_q    <= 2'd0;
            pts_gnt_q  <= 2'd0;
            team_q     <= TIME_B;
            d_a_q      <= '0;
            d_b_q      <= '0;
            perdido_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            perdido_q <= w_drop_a | w_drop_b;

            if (w_gnt_en) begin
                team_q    <= w_gnt_team;
                pts_gnt_q <= (w_gnt_team == TIME_A) ? pts_a_q : pts_b_q;
            end

            if (w_req_a && !w_drop_a) begin
                pend_a_q <= 1'b1;
                pts_a_q  <= bus.pts_a;
            end else if (w_gnt_a) begin
                pend_a_q <= 1'b0;
            end

            if (w_req_b && !w_drop_b) begin
                pend_b_q <= 1'b1;
                pts_b_q  <= bus.pts_b;
            end else if (w_gnt_b) begin
                pend_b_q <= 1'b0;
            end

            if (state_q == HOLD) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_q <= '0;
            end

            if (state_q == CALC) begin
                if (team_q == TIME_A) begin
                    d_a_q <= w_soma;
                end else begin
                    d_b_q <= w_soma;
                end
            end
        end
    end

    assign bus.d_a      = d_a_q;
    assign bus.d_b      = d_b_q;
    assign bus.valida_a = w_valida_a;
    assign bus.valida_b = w_valida_b;
    assign bus.busy     = w_busy;
    assign bus.perdido  = perdido_q;

endmodule : controlador_pontos_placar
`default_nettype wire
